pwm_fade_multi: RTL
===================

# pwm_fade_multi

Multi-channel PWM brightness controller with per-channel duty targets, glitch-free duty updates at period boundaries and an optional linear fade between the current and target brightness. It drives LED/lamp enables from a shared prescaled period counter. It replaces the single-channel fixed-duty PWM light driver in the lighting path.

## Interface

Parameters:
- CH, 4: number of independent PWM channels.
- DW, 7: width of each duty field, in percent-style steps.
- PERIOD, 100: counter steps per PWM period. A duty value of PERIOD means 100 %.
- PRESCALE, 10: clk cycles per counter step. Must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 forces reset state immediately.
- duty_target  in  CH*DW  packed targets; channel i occupies bits [i*DW +: DW].
- load  in  1  one-cycle strobe that captures duty_target into the target registers.
- pwm_out  out  CH  registered PWM outputs.
- busy  out  CH  high while channel current duty differs from its target.
- period_start  out  1  one-clk pulse on the cycle in which the period counter wraps to 0.

## Operation

- Prescaler presc counts 0..PRESCALE-1 and wraps. tick is asserted when presc==PRESCALE-1.
- On each tick, period counter cnt advances: 0..PERIOD-1, then wraps to 0.
- wrap is defined as tick && cnt==PERIOD-1. period_start is registered from wrap, so it is high for the one cycle in which cnt reads 0.
- Each channel holds a target register tgt[i] and a current-duty register cur[i], both DW bits.
- On load=1, each tgt[i] is updated to min(duty_target slice, PERIOD). Values above PERIOD are clamped to PERIOD.
- cur[i] changes only on wrap. This makes duty updates glitch-free: a period never mixes two duties.
- pwm_out[i] is registered from the comparison cnt < cur[i]:
  - cur=0 gives a constantly low output.
  - cur=PERIOD gives a constantly high output.
- busy[i] = (cur[i] != tgt[i]). It is driven combinationally from registers only.
- Simultaneous load and wrap: the cur update on that wrap uses the old tgt. The new tgt is acted on from the next wrap onward.
- Channels are fully independent. They share only presc and cnt.

## Timing

- Reset values: presc=0, cnt=0, cur=0, tgt=0, pwm_out=0, period_start=0, busy=0.
- Reset taking effect mid-period or mid-fade discards all state. After release, outputs stay low until a new load arrives and the next wrap occurs.
- After rst is released, the first tick is at clk cycle PRESCALE, and the first wrap is at cycle PRESCALE*PERIOD.
- PWM period is PRESCALE*PERIOD clk cycles. With the defaults this is 1000 clk cycles.
- High time per period is cur*PRESCALE clk cycles.
- pwm_out lags cnt by one clk cycle. A rising edge of pwm_out occurs one cycle after cnt becomes 0.
- Latency from load to the target being visible on busy is one cycle.
- Latency from load to the first duty change is the next wrap, at most PRESCALE*PERIOD cycles.
- Arithmetic: cur is incremented or decremented by 1 only when different from tgt, so it never overflows and never underflows.
- cnt width is clog2(PERIOD). presc width is clog2(PRESCALE), with a minimum of 1.

## Configuration

- PWM_FADE_EN defined: on each wrap, cur[i] moves one step toward tgt[i] (+1 or −1). A full 0→PERIOD fade takes PERIOD periods. busy stays high until the wrap at which cur reaches tgt.
- PWM_FADE_EN undefined: on each wrap, cur[i] is set to tgt[i] in a single step. busy is high only from load until the next wrap.

## Test plan

- Reset:
  - Stimulus: hold rst=0 for 20 cycles, then release with no load for 3000 cycles.
  - Required: pwm_out=0, busy=0 throughout; period_start pulses at cycles 1000, 2000, 3000 after release.
- Immediate update (PWM_FADE_EN undefined):
  - Stimulus: load ch0=25, ch1=75.
  - Required: after the next period_start, ch0 is high 250 of every 1000 cycles and ch1 is high 750. busy falls on that wrap.
- Fade (PWM_FADE_EN defined):
  - Stimulus: load ch0=50 from 0.
  - Required: high time grows by 10 cycles per period. busy deasserts after the 50th wrap. Steady state is 500/1000.
  - Stimulus: then load ch0=20.
  - Required: 30 descending periods, then steady state.
- Clamp and extremes:
  - Stimulus: load 127 on ch2.
  - Required: cur saturates at 100 and pwm_out[2] is constantly high.
  - Stimulus: then load 0.
  - Required: pwm_out[2] is constantly low after settling.
- Collision and reset mid-operation:
  - Stimulus: assert load in the same cycle as wrap (wrap high, i.e. the cycle before period_start).
  - Required: the old target is applied on that wrap, and the new target from the following wrap.
  - Stimulus: assert rst=0 halfway through a fade.
  - Required: all outputs go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM brightness controller with duty updates at period boundaries.
// Define PWM_FADE_EN to step each channel one unit per period toward its target.
module pwm_fade_multi #(
    parameter int CH       = 4,
    parameter int DW       = 7,
    parameter int PERIOD   = 100,
    parameter int PRESCALE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*DW-1:0]  duty_target,
    input  logic              load,
    output logic [CH-1:0]     pwm_out,
    output logic [CH-1:0]     busy,
    output logic              period_start
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [DW-1:0] FULL       = DW'(PERIOD);

    logic [PW-1:0] presc;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          wrap;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            period_start <= wrap;
            if (tick) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DW-1:0] slice;
        logic [31:0]   slice_w;
        logic [DW-1:0] clamped;
        logic [DW-1:0] cur_q;
        logic [DW-1:0] tgt_q;
        logic [DW-1:0] cur_next;
        logic          pwm_q;
        logic          below;

        assign slice   = duty_target[i*DW +: DW];
        assign slice_w = 32'(slice);
        assign clamped = (slice_w > 32'(PERIOD)) ? FULL : slice;

        // Zero-extend both operands to a common width before comparing
        assign below = {{DW{1'b0}}, cnt} < {{CW{1'b0}}, cur_q};

`ifdef PWM_FADE_EN
        always_comb begin
            cur_next = cur_q;
            if (cur_q < tgt_q) begin
                cur_next = cur_q + 1'b1;
            end else if (cur_q > tgt_q) begin
                cur_next = cur_q - 1'b1;
            end
        end
`else
        always_comb begin
            cur_next = tgt_q;
        end
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tgt_q <= '0;
                cur_q <= '0;
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= below;
                if (load) begin
                    tgt_q <= clamped;
                end
                // cur only moves on wrap, so a period never mixes duties
                if (wrap) begin
                    cur_q <= cur_next;
                end
            end
        end

        assign pwm_out[i] = pwm_q;
        assign busy[i]    = (cur_q != tgt_q);
    end

endmodule
